reservation_station: RTL and testbench

//   Holds instructions dispatched by the ROB until both source operands are

---
 rtl/reservation_station.sv | 215 +++++++++++++++++++++
 tb/tb_reservation_station.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// reservation_station
//   Holds instructions dispatched by the ROB until both source operands are
//   available, snoops the ALU and memory result buses for the tags it is
//   waiting on, and releases at most one ready instruction per cycle to the
//   ALU through a registered output stage.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   op_in .. imm_in          dispatch from the ROB (op_in all-ones = none)
//   alu_num / alu_value      ALU broadcast (tag 0 = idle)
//   mem_num / mem_value      memory broadcast (tag 0 = idle)
//   flush                    discard every entry and the pending issue
//   rs_full                  at most one free entry left
//   alu_op .. alu_tag        registered issue to the ALU (alu_op all-ones = none)
module reservation_station #(
  parameter int RS_DEPTH = 4,
  parameter int TAG_W    = 3,
  parameter int OP_W     = 5,
  parameter int XLEN     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op_in,
  input  logic [XLEN-1:0]  value1_in,
  input  logic [XLEN-1:0]  value2_in,
  input  logic [TAG_W-1:0] query1_in,
  input  logic [TAG_W-1:0] query2_in,
  input  logic [TAG_W-1:0] target_in,
  input  logic [XLEN-1:0]  imm_in,
  input  logic [TAG_W-1:0] alu_num,
  input  logic [XLEN-1:0]  alu_value,
  input  logic [TAG_W-1:0] mem_num,
  input  logic [XLEN-1:0]  mem_value,
  input  logic             flush,
  output logic             rs_full,
  output logic [OP_W-1:0]  alu_op,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [XLEN-1:0]  alu_imm,
  output logic [TAG_W-1:0] alu_tag
);

  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RS_DEPTH) + 1;
  localparam logic [OP_W-1:0] OP_NONE = '1;

  // Entry state
  logic [RS_DEPTH-1:0] busy_q, busy_d;
  logic [OP_W-1:0]     op_q  [RS_DEPTH];
  logic [OP_W-1:0]     op_d  [RS_DEPTH];
  logic [XLEN-1:0]     v1_q  [RS_DEPTH];
  logic [XLEN-1:0]     v1_d  [RS_DEPTH];
  logic [XLEN-1:0]     v2_q  [RS_DEPTH];
  logic [XLEN-1:0]     v2_d  [RS_DEPTH];
  logic [TAG_W-1:0]    q1_q  [RS_DEPTH];
  logic [TAG_W-1:0]    q1_d  [RS_DEPTH];
  logic [TAG_W-1:0]    q2_q  [RS_DEPTH];
  logic [TAG_W-1:0]    q2_d  [RS_DEPTH];
  logic [TAG_W-1:0]    tag_q [RS_DEPTH];
  logic [TAG_W-1:0]    tag_d [RS_DEPTH];
  logic [XLEN-1:0]     imm_q [RS_DEPTH];
  logic [XLEN-1:0]     imm_d [RS_DEPTH];

  // Issue register
  logic [OP_W-1:0]  alu_op_q,  alu_op_d;
  logic [XLEN-1:0]  alu_a_q,   alu_a_d;
  logic [XLEN-1:0]  alu_b_q,   alu_b_d;
  logic [XLEN-1:0]  alu_imm_q, alu_imm_d;
  logic [TAG_W-1:0] alu_tag_q, alu_tag_d;

  logic [CNT_W-1:0] busy_count;
  logic             iss_vld;
  logic [IDX_W-1:0] iss_idx;
  logic             free_vld;
  logic [IDX_W-1:0] free_idx;
  logic             dispatch;

  // Operand capture shared by wakeup and dispatch bypass. Tag 0 never
  // matches, and the ALU bus wins when both buses carry the same tag.
  function automatic logic [TAG_W-1:0] capture_q(input logic [TAG_W-1:0] q,
                                                  input logic [TAG_W-1:0] an,
                                                  input logic [TAG_W-1:0] mn);
    if (q != '0 && (q == an || q == mn)) return '0;
    return q;
  endfunction

  function automatic logic [XLEN-1:0] capture_v(input logic [TAG_W-1:0] q,
                                                 input logic [XLEN-1:0]  v,
                                                 input logic [TAG_W-1:0] an,
                                                 input logic [XLEN-1:0]  av,
                                                 input logic [TAG_W-1:0] mn,
                                                 input logic [XLEN-1:0]  mv);
    if (q != '0 && q == an) return av;
    if (q != '0 && q == mn) return mv;
    return v;
  endfunction

  // Selection on pre-edge state: lowest ready entry issues, lowest free
  // entry receives a dispatch. A slot freed by this edge's issue is still
  // busy here, so it is never reused on the same edge.
  always_comb begin
    busy_count = '0;
    iss_vld    = 1'b0;
    iss_idx    = '0;
    free_vld   = 1'b0;
    free_idx   = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      busy_count = busy_count + CNT_W'(busy_q[i]);
      if (busy_q[i] && q1_q[i] == '0 && q2_q[i] == '0) begin
        iss_vld = 1'b1;
        iss_idx = IDX_W'(i);
      end
      if (!busy_q[i]) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign dispatch = (op_in != OP_NONE);
  assign rs_full  = (busy_count >= CNT_W'(RS_DEPTH - 1));

  always_comb begin
    busy_d    = busy_q;
    op_d      = op_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    q1_d      = q1_q;
    q2_d      = q2_q;
    tag_d     = tag_q;
    imm_d     = imm_q;
    alu_op_d  = OP_NONE;
    alu_tag_d = '0;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_imm_d = alu_imm_q;

    if (flush) begin
      busy_d    = '0;
      alu_a_d   = '0;
      alu_b_d   = '0;
      alu_imm_d = '0;
    end else begin
      // Issue reads the stored operands, before any wakeup on this edge.
      if (iss_vld) begin
        alu_op_d  = op_q[iss_idx];
        alu_a_d   = v1_q[iss_idx];
        alu_b_d   = v2_q[iss_idx];
        alu_imm_d = imm_q[iss_idx];
        alu_tag_d = tag_q[iss_idx];
      end

      for (int i = 0; i < RS_DEPTH; i++) begin
        if (busy_q[i]) begin
          v1_d[i] = capture_v(q1_q[i], v1_q[i], alu_num, alu_value, mem_num, mem_value);
          q1_d[i] = capture_q(q1_q[i], alu_num, mem_num);
          v2_d[i] = capture_v(q2_q[i], v2_q[i], alu_num, alu_value, mem_num, mem_value);
          q2_d[i] = capture_q(q2_q[i], alu_num, mem_num);
        end
      end

      if (dispatch && free_vld) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = op_in;
        v1_d[free_idx]   = capture_v(query1_in, value1_in, alu_num, alu_value, mem_num, mem_value);
        q1_d[free_idx]   = capture_q(query1_in, alu_num, mem_num);
        v2_d[free_idx]   = capture_v(query2_in, value2_in, alu_num, alu_value, mem_num, mem_value);
        q2_d[free_idx]   = capture_q(query2_in, alu_num, mem_num);
        tag_d[free_idx]  = target_in;
        imm_d[free_idx]  = imm_in;
      end

      if (iss_vld) busy_d[iss_idx] = 1'b0;
    end
  end

  // Control and issue-register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      alu_op_q  <= OP_NONE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_imm_q <= '0;
      alu_tag_q <= '0;
    end else begin
      busy_q    <= busy_d;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_imm_q <= alu_imm_d;
      alu_tag_q <= alu_tag_d;
      // A dispatch into a completely full station is lost.
      assert (flush || !dispatch || free_vld);
    end
  end

  // Entry payload boundary; qualified by busy_q, so no reset needed
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    v1_q  <= v1_d;
    v2_q  <= v2_d;
    q1_q  <= q1_d;
    q2_q  <= q2_d;
    tag_q <= tag_d;
    imm_q <= imm_d;
  end

  assign alu_op  = alu_op_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_imm = alu_imm_q;
  assign alu_tag = alu_tag_q;

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  op_in;
  logic [31:0] value1_in, value2_in, imm_in, alu_value, mem_value;
  logic [2:0]  query1_in, query2_in, target_in, alu_num, mem_num;
  logic        flush;
  logic        rs_full;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_imm;
  logic [2:0]  alu_tag;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  reservation_station #(.RS_DEPTH(D), .TAG_W(3), .OP_W(5), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .op_in(op_in), .value1_in(value1_in),
    .value2_in(value2_in), .query1_in(query1_in), .query2_in(query2_in),
    .target_in(target_in), .imm_in(imm_in), .alu_num(alu_num),
    .alu_value(alu_value), .mem_num(mem_num), .mem_value(mem_value),
    .flush(flush), .rs_full(rs_full), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_imm(alu_imm), .alu_tag(alu_tag)
  );

  always #5 clk = ~clk;

  // Behavioural model: a table of waiting instructions
  typedef struct {
    bit          busy;
    logic [4:0]  op;
    logic [31:0] v1, v2, imm;
    logic [2:0]  q1, q2, tag;
  } ent_t;

  ent_t        m [D];
  logic [4:0]  e_op  = 5'h1f;
  logic [31:0] e_a   = 0, e_b = 0, e_imm = 0;
  logic [2:0]  e_tag = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resolve(input logic [2:0] q, input logic [31:0] v,
                         output logic [2:0] qo, output logic [31:0] vo);
    qo = q;
    vo = v;
    if (q != 0 && q == alu_num) begin
      qo = 0; vo = alu_value;
    end else if (q != 0 && q == mem_num) begin
      qo = 0; vo = mem_value;
    end
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    int iss = -1;
    int fr  = -1;
    if (rst || flush) begin
      for (int i = 0; i < D; i++) m[i].busy = 0;
      e_op = 5'h1f; e_tag = 0; e_a = 0; e_b = 0; e_imm = 0;
      return;
    end
    for (int i = 0; i < D; i++) begin
      if (iss < 0 && m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) iss = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    if (iss >= 0) begin
      e_op = m[iss].op; e_a = m[iss].v1; e_b = m[iss].v2;
      e_imm = m[iss].imm; e_tag = m[iss].tag;
    end else begin
      e_op = 5'h1f; e_tag = 0;
    end
    for (int i = 0; i < D; i++)
      if (m[i].busy) begin
        resolve(m[i].q1, m[i].v1, m[i].q1, m[i].v1);
        resolve(m[i].q2, m[i].v2, m[i].q2, m[i].v2);
      end
    if (op_in != 5'h1f && fr >= 0) begin
      m[fr].busy = 1; m[fr].op = op_in; m[fr].tag = target_in; m[fr].imm = imm_in;
      resolve(query1_in, value1_in, m[fr].q1, m[fr].v1);
      resolve(query2_in, value2_in, m[fr].q2, m[fr].v2);
    end
    if (iss >= 0) m[iss].busy = 0;
  endtask

  function automatic logic model_full();
    int c = 0;
    for (int i = 0; i < D; i++) c += int'(m[i].busy);
    return c >= D - 1;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_rs_full", 32'(rs_full), 32'(model_full()));
      check("m_alu_op",  32'(alu_op),  32'(e_op));
      check("m_alu_tag", 32'(alu_tag), 32'(e_tag));
      check("m_alu_a",   alu_a,   e_a);
      check("m_alu_b",   alu_b,   e_b);
      check("m_alu_imm", alu_imm, e_imm);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    op_in = 5'h1f; value1_in = 0; value2_in = 0; imm_in = 0;
    query1_in = 0; query2_in = 0; target_in = 0;
    alu_num = 0; alu_value = 0; mem_num = 0; mem_value = 0; flush = 0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [2:0] q1, input logic [2:0] q2, input logic [2:0] tag,
                      input logic [31:0] imm);
    op_in = op; value1_in = v1; value2_in = v2; query1_in = q1;
    query2_in = q2; target_in = tag; imm_in = imm;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    cmp_en = 1;

    // 1: quiet after reset
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_full", 32'(rs_full), 0);
      check("rst_op", 32'(alu_op), 32'h1f);
      check("rst_tag", 32'(alu_tag), 0);
    end

    // 2: ready ADD issues on the next edge for one cycle
    disp(5'd0, 32'd5, 32'd7, 0, 0, 3'd2, 32'h11);
    tick();
    idle();
    tick();
    check("add_op", 32'(alu_op), 0);
    check("add_a", alu_a, 5);
    check("add_b", alu_b, 7);
    check("add_tag", 32'(alu_tag), 2);
    tick();
    check("add_gone", 32'(alu_op), 32'h1f);

    // 3: waits on tag 2, then woken by ALU bus
    disp(5'd1, 32'd0, 32'd1, 3'd2, 0, 3'd3, 0);
    tick();
    idle();
    tick();
    check("sub_wait1", 32'(alu_op), 32'h1f);
    tick();
    check("sub_wait2", 32'(alu_op), 32'h1f);
    alu_num = 3'd2; alu_value = 32'h10;
    tick();
    idle();
    tick();
    check("sub_a", alu_a, 32'h10);
    check("sub_tag", 32'(alu_tag), 3);

    // 4: same-cycle bypass on dispatch
    disp(5'd2, 32'd0, 32'd3, 3'd4, 0, 3'd4, 0);
    alu_num = 3'd4; alu_value = 32'd9;
    tick();
    idle();
    tick();
    check("byp_a", alu_a, 9);
    check("byp_tag", 32'(alu_tag), 4);

    // 5: fill all four entries, release in index order
    for (int t = 4; t < 8; t++) begin
      disp(5'd3, 32'd0, 32'(t), 3'd1, 0, 3'(t), 0);
      tick();
      if (t == 6) check("full_at3", 32'(rs_full), 1);
    end
    check("full_at4", 32'(rs_full), 1);
    idle();
    alu_num = 3'd1; alu_value = 32'h77;
    tick();
    idle();
    for (int t = 4; t < 8; t++) begin
      tick();
      check("order_tag", 32'(alu_tag), 32'(t));
      check("order_a", alu_a, 32'h77);
    end
    tick();
    check("order_done", 32'(alu_op), 32'h1f);
    check("order_empty", 32'(rs_full), 0);

    // ALU bus wins over memory bus on equal tags; memory bus alone wakes q2
    disp(5'd4, 32'd0, 32'd0, 3'd3, 3'd3, 3'd5, 0);
    tick();
    idle();
    alu_num = 3'd3; alu_value = 32'haa; mem_num = 3'd3; mem_value = 32'hbb;
    tick();
    idle();
    tick();
    check("prio_a", alu_a, 32'haa);
    check("prio_b", alu_b, 32'haa);
    disp(5'd5, 32'd1, 32'd0, 0, 3'd6, 3'd2, 32'h3);
    tick();
    idle();
    mem_num = 3'd6; mem_value = 32'h55;
    tick();
    idle();
    tick();
    check("mem_b", alu_b, 32'h55);
    check("mem_imm", alu_imm, 3);

    // Back-to-back ready dispatches
    disp(5'd6, 32'd1, 32'd2, 0, 0, 3'd1, 0);
    tick();
    disp(5'd7, 32'd3, 32'd4, 0, 0, 3'd2, 0);
    tick();
    check("b2b_first", 32'(alu_tag), 1);
    idle();
    tick();
    check("b2b_second", 32'(alu_tag), 2);
    tick();

    // 6: flush drops waiting entries and a same-cycle dispatch
    for (int t = 1; t < 4; t++) begin
      disp(5'd8, 32'd0, 32'd0, 3'd5, 0, 3'(t), 0);
      tick();
    end
    disp(5'd9, 32'd1, 32'd1, 0, 0, 3'd4, 0);
    flush = 1;
    tick();
    idle();
    check("flush_full", 32'(rs_full), 0);
    check("flush_op", 32'(alu_op), 32'h1f);
    tick();
    check("flush_op2", 32'(alu_op), 32'h1f);
    alu_num = 3'd5; alu_value = 32'h1234;
    tick();
    idle();
    tick();
    tick();
    check("flush_late", 32'(alu_op), 32'h1f);

    // 7: reset on the issuing edge
    disp(5'd3, 32'd8, 32'd8, 0, 0, 3'd6, 0);
    tick();
    idle();
    rst = 1;
    tick();
    check("rst_iss_op", 32'(alu_op), 32'h1f);
    check("rst_iss_tag", 32'(alu_tag), 0);
    rst = 0;
    tick();
    tick();
    check("rst_gone", 32'(alu_op), 32'h1f);

    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
